nand_share_arbiter: RTL

NAND_SHARE_ARBITER -- requirements
Module: nand_share_arbiter

---
 rtl/nand_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/nand_share_arbiter.sv
// -----------------------------------------------------------------------------
// nand_share_arbiter
//
// Shares one NAND datapath between four requesters. A round-robin arbiter
// picks a winner in IDLE, captures that requester's operands, computes
// ~(A & B) in EXEC and pulses ack in DONE before going back to IDLE. Each
// operation takes three cycles. The next operation can start one cycle later
// at the earliest.
//
// Parameters
//   WIDTH     operand and result width (default 8)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req[3:0]  request, one bit per requester
//   a, b      packed operands; requester i owns bits [i*WIDTH +: WIDTH]
//   gnt[3:0]  one-hot grant, held through EXEC and DONE
//   ack[3:0]  one-hot completion pulse, high in DONE only
//   result    registered NAND result; updates only on the EXEC->DONE edge
//   busy      high whenever the FSM is not in IDLE
//   op_count  completed-operation counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module nand_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a,
    input  logic [4*WIDTH-1:0]   b,
    output logic [3:0]           gnt,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic [7:0]           op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [1:0]       pick;
    logic             pick_valid;
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;

    // Round-robin search. The search starts at ptr and walks ptr, ptr+1, ...
    // The 2-bit sum wraps modulo 4 by itself.
    always_comb begin
        // NOTE: give every always_comb output a default before any branch.
        // Then no path leaves it unassigned, and no latch is inferred.
        pick       = ptr;
        pick_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!pick_valid && req[ptr + 2'(i)]) begin
                pick       = ptr + 2'(i);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: use non-blocking assignments for every register. Each edge
        // then reads the old values, whatever order the statements are in.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'd0;
            winner   <= 2'd0;
            gnt      <= 4'b0000;
            ack      <= 4'b0000;
            result   <= '0;
            op_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner <= pick;
                        gnt    <= 4'b0001 << pick;
                    end
                end
                EXEC: begin
                    result <= ~(a_cap & b_cap);
                    ack    <= gnt;
                end
                DONE: begin
                    gnt      <= 4'b0000;
                    ack      <= 4'b0000;
                    ptr      <= winner + 2'd1;
                    op_count <= op_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Operand capture happens only on the IDLE->EXEC edge. Later changes on
    // a or b therefore cannot reach the result.
    always_ff @(posedge clk) begin
        // NOTE: these registers have no reset. Each one is written before it
        // is read, so a reset would only add routing to the reset net.
        if (state == IDLE && pick_valid) begin
            a_cap <= a[pick*WIDTH +: WIDTH];
            b_cap <= b[pick*WIDTH +: WIDTH];
        end
    end

    assign busy = (state != IDLE);

endmodule
